// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single shared memory bus.
// Data has fixed priority; a stalled bus transfer is aborted after TIMEOUT wait cycles.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_ack,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        stall,
    output logic        err,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a requester holds req (and its address/data) high until it sees a
    // one-cycle ack; the bus completes a transfer in any cycle where bus_req and
    // bus_ready are both high.
    typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_wr_q, bus_wr_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        inst_ack_q, inst_ack_d;
    logic        data_ack_q, data_ack_d;
    logic        err_q, err_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            err_q        <= 1'b0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            wait_cnt_q   <= 8'h0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
            err_q        <= err_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_ack_d   = 1'b0;
        data_ack_d   = 1'b0;
        err_d        = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            IDLE: begin
                // A port whose ack is high this cycle is not re-granted yet.
                if (data_req && !data_ack_q) begin
                    state_d     = DBUSY;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = data_wr;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                    wait_cnt_d  = 8'h0;
                end else if (inst_req && !inst_ack_q) begin
                    state_d     = IBUSY;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = 1'b0;
                    bus_addr_d  = inst_addr;
                    bus_wdata_d = 32'h0;
                    wait_cnt_d  = 8'h0;
                end
            end
            IBUSY, DBUSY: begin
                if (bus_ready) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    if (state_q == IBUSY) begin
                        inst_rdata_d = bus_rdata;
                        inst_ack_d   = 1'b1;
                    end else begin
                        data_rdata_d = bus_rdata;
                        data_ack_d   = 1'b1;
                    end
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == IBUSY) begin
                        inst_rdata_d = 32'h0;
                        inst_ack_d   = 1'b1;
                    end else begin
                        data_rdata_d = 32'h0;
                        data_ack_d   = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inst_ack    = inst_ack_q;
    assign data_ack    = data_ack_q;
    assign inst_rdata  = inst_rdata_q;
    assign data_rdata  = data_rdata_q;
    assign bus_req     = bus_req_q;
    assign bus_wr      = bus_wr_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;
    assign stall       = (inst_req & ~inst_ack_q) | (data_req & ~data_ack_q);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles a granted bus transfer may wait for bus_ready (valid range 1..255).
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1, reset); one clock, reset asynchronous and active-high.
REQ-003 SHALL have inst_req in 1 (fetch request, level, held until inst_ack), inst_addr in 32 (fetch byte address).
REQ-004 SHALL have inst_ack out 1 (one-cycle completion pulse) and inst_rdata out 32 (fetched word).
REQ-005 SHALL have data_req in 1 (load/store request, level, held until data_ack), data_wr in 1 (1=store), data_addr in 32, data_wdata in 32.
REQ-006 SHALL have data_ack out 1 (one-cycle completion pulse) and data_rdata out 32 (load word).
REQ-007 SHALL have bus_req out 1, bus_wr out 1, bus_addr out 32, bus_wdata out 32 (shared single-port memory bus, all registered).
REQ-008 SHALL have bus_rdata in 32 and bus_ready in 1 (transfer complete in the cycle sampled high while bus_req=1).
REQ-009 SHALL have stall out 1 (pipeline freeze) and err out 1 (one-cycle pulse with ack on timeout).

Function
REQ-010 SHALL implement FSM states IDLE, IBUSY, DBUSY.
REQ-011 In IDLE, a requester is eligible when its req=1 and its ack output is 0 in that cycle.
REQ-012 In IDLE, if data eligible, SHALL go to DBUSY; else if inst eligible, go to IBUSY; else stay IDLE. Data has fixed priority.
REQ-013 On grant edge, SHALL register bus_req=1, bus_addr, bus_wr (data_wr for data, 0 for fetch), bus_wdata (data_wdata for data, 0 for fetch); all hold stable until completion.
REQ-014 Requester address/data changes after grant SHALL be ignored until the next grant.
REQ-015 In IBUSY/DBUSY with bus_ready=1, SHALL on that edge: bus_req<=0, capture bus_rdata into the granted rdata register (stores also capture), granted ack<=1, state<=IDLE.
REQ-016 Ack SHALL be high exactly one cycle; rdata registers SHALL hold their value until the next completion for that port.
REQ-017 Minimum transfer: grant edge, bus_ready in the next cycle, ack in the cycle after; 3 cycles req-to-ack for a zero-wait bus.
REQ-018 A new grant SHALL NOT occur in the cycle ack is high for the same port; the other port may be granted in that cycle.
REQ-019 SHALL keep an 8-bit wait counter cleared on grant and incremented each busy cycle with bus_ready=0.
REQ-020 When the counter equals TIMEOUT and bus_ready=0, SHALL on that edge: bus_req<=0, rdata<=32'h0, granted ack<=1, err<=1, state<=IDLE.
REQ-021 If bus_ready=1 in the same cycle the counter equals TIMEOUT, normal completion (REQ-015) SHALL win and err SHALL stay 0.
REQ-022 bus_ready while bus_req=0 SHALL be ignored.
REQ-023 stall SHALL be combinational: (inst_req & ~inst_ack) | (data_req & ~data_ack).
REQ-024 Simultaneous inst_req and data_req from IDLE: data served first, fetch granted in the cycle data_ack is high.

Reset
REQ-025 On rst=1, without waiting for clk: state=IDLE, bus_req=0, bus_wr=0, bus_addr=0, bus_wdata=0, inst_ack=0, data_ack=0, err=0, inst_rdata=0, data_rdata=0, counter=0.
REQ-026 Reset mid-transfer SHALL abandon the transfer without an ack; after release, requests still held are re-arbitrated from IDLE.

Verification
REQ-027 inst_req=1, inst_addr=0xBFC00000, bus_ready=1 the cycle after bus_req rises, bus_rdata=0x24080001 -> bus_addr=0xBFC00000, bus_wr=0, inst_ack pulses on cycle 3 with inst_rdata=0x24080001, stall 1 for cycles 1-2.
REQ-028 inst_req and data_req (wr=1, addr=0x10, wdata=0xCAFEF00D) high together -> store granted first (bus_wr=1, bus_wdata=0xCAFEF00D), data_ack pulses, fetch granted that same cycle, inst_ack follows 2 cycles later.
REQ-029 data load with bus_ready held 0, TIMEOUT=4 -> bus_req drops after 5 busy cycles, data_ack=1 with err=1, data_rdata=0.
REQ-030 bus_ready=1 exactly when counter=TIMEOUT, bus_rdata=0x12345678 -> data_ack=1, err=0, data_rdata=0x12345678.
REQ-031 rst pulsed while DBUSY with bus_req=1 -> bus_req, acks, err go 0 immediately; after release with data_req still 1, a fresh grant occurs on the next edge.
REQ-032 data_addr changed from 0x20 to 0x40 one cycle after grant -> bus_addr stays 0x20 until completion.
